// File: rtl/decode_stage.sv
`default_nettype none
// decode_stage: single-entry RV32I decode buffer with register-file read
// addressing, one-cycle writeback bypass and immediate generation.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [4:0]  ex_rd,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b5,
  output logic        ex_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic        s_valid;
  logic [31:0] s_instr;
  logic [31:0] s_pc;
  logic        wbq_valid;
  logic [4:0]  wbq_rd;
  logic [31:0] wbq_data;
  logic        accept;
  logic [4:0]  s_rs1;
  logic [4:0]  s_rs2;
  logic [6:0]  s_opcode;
  logic [31:0] imm;
  logic        illegal;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  // Flush forces acceptance so a redirect target is never stalled behind a dead entry.
  assign if_ready = !s_valid | ex_ready | flush;
  assign accept   = if_valid & if_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid <= 1'b0;
      s_instr <= '0;
      s_pc    <= '0;
    end else if (accept) begin
      s_valid <= 1'b1;
      s_instr <= if_instr;
      s_pc    <= if_pc;
    end else if (flush | ex_ready) begin
      s_valid <= 1'b0;
    end
  end

  // The RF read at this edge misses the write at the same edge; keep it for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbq_valid <= 1'b0;
      wbq_rd    <= '0;
      wbq_data  <= '0;
    end else begin
      wbq_valid <= wb_valid;
      wbq_rd    <= wb_rd;
      wbq_data  <= wb_data;
    end
  end

  assign s_rs1    = s_instr[19:15];
  assign s_rs2    = s_instr[24:20];
  assign s_opcode = s_instr[6:0];

  assign rf_rs1 = if_ready ? if_instr[19:15] : s_rs1;
  assign rf_rs2 = if_ready ? if_instr[24:20] : s_rs2;

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (s_opcode)
      OP_LOAD, OP_IMM, OP_JALR:
        imm = {{20{s_instr[31]}}, s_instr[31:20]};
      OP_STORE:
        imm = {{20{s_instr[31]}}, s_instr[31:25], s_instr[11:7]};
      OP_BRANCH:
        imm = {{19{s_instr[31]}}, s_instr[31], s_instr[7], s_instr[30:25], s_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {s_instr[31:12], 12'b0};
      OP_JAL:
        imm = {{11{s_instr[31]}}, s_instr[31], s_instr[19:12], s_instr[20], s_instr[30:21], 1'b0};
      OP_REG, OP_FENCE, OP_SYSTEM:
        imm = '0;
      default:
        illegal = 1'b1;
    endcase
    if (s_instr[1:0] != 2'b11) illegal = 1'b1;
  end

  always_comb begin
    rs1_val = rf_rdata1;
    rs2_val = rf_rdata2;
    if (wbq_valid && (wbq_rd != 5'd0) && (wbq_rd == s_rs1)) rs1_val = wbq_data;
    if (wbq_valid && (wbq_rd != 5'd0) && (wbq_rd == s_rs2)) rs2_val = wbq_data;
    if (s_rs1 == 5'd0) rs1_val = '0;
    if (s_rs2 == 5'd0) rs2_val = '0;
  end

  // Everything toward execute reads as zero while the stage is empty.
  assign ex_valid    = s_valid;
  assign ex_pc       = s_valid ? s_pc : '0;
  assign ex_imm      = s_valid ? imm : '0;
  assign ex_rs1_val  = s_valid ? rs1_val : '0;
  assign ex_rs2_val  = s_valid ? rs2_val : '0;
  assign ex_rd       = s_valid ? s_instr[11:7] : '0;
  assign ex_opcode   = s_valid ? s_opcode : '0;
  assign ex_funct3   = s_valid ? s_instr[14:12] : '0;
  assign ex_funct7b5 = s_valid & s_instr[30];
  assign ex_illegal  = s_valid & illegal;

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters: none; all datapaths are 32 bits and all register indices are 5 bits.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 if_valid  in  1  fetch presents an instruction.
REQ-005 if_ready  out  1  decode accepts the instruction; transfer occurs when if_valid & if_ready at posedge.
REQ-006 if_instr  in  32  instruction word.
REQ-007 if_pc  in  32  PC of if_instr.
REQ-008 flush  in  1  discard the held instruction (branch redirect).
REQ-009 rf_rs1, rf_rs2  out  5  register file read addresses; data returns one clock later.
REQ-010 rf_rdata1, rf_rdata2  in  32  registered register file read data.
REQ-011 wb_valid, wb_rd, wb_data  in  1/5/32  writeback write presented to the register file this cycle.
REQ-012 ex_valid  out  1  decoded instruction valid toward execute.
REQ-013 ex_ready  in  1  execute accepts; transfer when ex_valid & ex_ready at posedge.
REQ-014 ex_pc, ex_imm, ex_rs1_val, ex_rs2_val  out  32 each  PC, sign-extended immediate, operand values.
REQ-015 ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_illegal  out  5/7/3/1/1  decoded fields; ex_illegal flags an unsupported opcode.

Function
REQ-016 A single holding stage (s_valid, s_instr, s_pc) SHALL be present; if_ready = !s_valid | ex_ready (combinational).
REQ-017 On if_valid & if_ready the stage SHALL load if_instr/if_pc and set s_valid; otherwise, on ex_ready it SHALL clear s_valid; otherwise it holds.
REQ-018 Latency: an instruction accepted at edge N SHALL drive ex_valid=1 during cycle N+1; sustained throughput SHALL be one instruction per cycle.
REQ-019 rf_rs1/rf_rs2 SHALL be if_instr[19:15]/[24:20] when if_ready=1, otherwise s_instr[19:15]/[24:20], so read data always matches the held instruction, including during stalls.
REQ-020 Bypass: wb_valid/wb_rd/wb_data SHALL be registered each cycle; if the registered wb_valid=1, wb_rd!=0 and wb_rd equals the held rs1 (or rs2), ex_rs1_val (or ex_rs2_val) SHALL equal the registered wb_data instead of rf_rdata.
REQ-021 rs1 or rs2 index 0 SHALL yield operand 0, regardless of rf_rdata or bypass.
REQ-022 Immediate by opcode: I (0000011, 0010011, 1100111), S (0100011), B (1100011, bit0=0), U (0110111, 0010111, low 12 bits zero), J (1101111, bit0=0); R-type (0110011) and others SHALL give 0; sign bit is instr[31].
REQ-023 ex_illegal SHALL be 1 when s_instr[1:0]!=2'b11 or the opcode is not one of the RV32I opcodes in REQ-022 plus 0110011, 0001111, 1110011.
REQ-024 Decoded outputs SHALL be combinational from held state and SHALL remain stable while ex_valid=1 & ex_ready=0.
REQ-025 flush SHALL clear s_valid at the next edge, with priority over hold. If if_valid=1 in the same cycle, the new instruction SHALL be accepted (if_ready=1 is forced during flush), and s_valid=1 with the new instruction.
REQ-026 Simultaneous accept and drain (ex_ready=1, if_valid=1) SHALL replace the held instruction with no bubble.

Reset
REQ-027 While rst_n=0: s_valid=0, s_instr=0, s_pc=0, and the registered bypass state is 0. Outputs: ex_valid=0, if_ready=1, all ex_* data outputs 0.
REQ-028 Reset assertion mid-stall SHALL drop the held instruction immediately and asynchronously. After release, the first accept SHALL behave as in REQ-018.

Verification
REQ-029 Reset then if_instr=0x00500093 (addi x1,x0,5), ex_ready=1 -> next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_rs1_val=0, ex_illegal=0.
REQ-030 Store 0xFE112E23 (sw x1,-4(x2)), RF x1=0xAA, x2=0x100 -> ex_imm=0xFFFFFFFC, ex_rs1_val=0x100, ex_rs2_val=0xAA.
REQ-031 wb_valid=1, wb_rd=3, wb_data=0x1234 on the same cycle that add x4,x3,x3 is accepted (RF x3 old=7) -> ex_rs1_val=ex_rs2_val=0x1234.
REQ-032 ex_ready=0 for 3 cycles with instruction held -> if_ready=0, outputs unchanged; wb write to the held rs1 during the stall is reflected by the next cycle.
REQ-033 flush with s_valid=1, if_valid=0 -> ex_valid=0 next cycle; with if_valid=1 -> new instruction presented next cycle.
REQ-034 if_instr=0x0000000B (custom opcode) -> ex_illegal=1, ex_imm=0; rst_n pulsed low mid-stall -> ex_valid=0 immediately.
